// File: rtl/mem_access_unit_if.sv
// Request/response and data-RAM bus of mem_access_unit.
// The slave modport is the unit's view; the master modport is the view of
// the surrounding CPU stage and RAM.
interface mem_access_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  logic        respValid;
  logic        respErr;
  logic [31:0] respData;
  logic        memEn;
  logic        memRw;
  logic [31:0] memAddr;
  logic [31:0] memDataOut;
  logic [31:0] memDataIn;

  modport slave (
    input  reqValid, reqWrite, reqFunct3, reqAddr, reqData, memDataIn,
    output reqReady, respValid, respErr, respData,
    output memEn, memRw, memAddr, memDataOut
  );

  modport master (
    output reqValid, reqWrite, reqFunct3, reqAddr, reqData, memDataIn,
    input  reqReady, respValid, respErr, respData,
    input  memEn, memRw, memAddr, memDataOut
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: RISC-V load/store initiator for a word-wide data RAM with
// a one-cycle registered read. Sub-word stores use read-modify-write.
// Optional build macro MEM_ACCESS_COUNTERS_EN adds load/store/error counters.
module mem_access_unit #(
  parameter int unsigned ADDR_BITS = 11
) (
  input logic clk,
  input logic rst,
  mem_access_unit_if.slave bus
`ifdef MEM_ACCESS_COUNTERS_EN
  ,
  output logic [15:0] loadCount,
  output logic [15:0] storeCount,
  output logic [15:0] errCount
`endif
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, RESP} state_t;

  state_t      state, next_state;

  // Latched request
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] sdata_q;

  // Registered outputs and their next values
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_dout_q, mem_dout_d;

  logic        range_err, f3_err, align_err, accept;

  // Load data extraction with sign/zero extension
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    extract = {{24{b[7]}}, b};
      F3_BU:   extract = {24'd0, b};
      F3_H:    extract = {{16{h[15]}}, h};
      F3_HU:   extract = {16'd0, h};
      default: extract = word;
    endcase
  endfunction

  // Byte/halfword merge into the word read back from RAM
  function automatic logic [31:0] merge(input logic [31:0] word,
                                        input logic [2:0]  f3,
                                        input logic [1:0]  lane,
                                        input logic [15:0] sdata);
    logic [31:0] m;
    m = word;
    if (f3[1:0] == 2'b00) m[{lane, 3'b000} +: 8] = sdata[7:0];
    else                  m[{lane[1], 4'b0000} +: 16] = sdata;
    merge = m;
  endfunction

  // Request checks, next state and next registered outputs
  always_comb begin
    next_state  = state;
    range_err   = 1'b0;
    f3_err      = 1'b0;
    align_err   = 1'b0;
    accept      = 1'b0;
    ready_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d  = 1'b0;
    resp_data_d = 32'd0;
    mem_en_d    = 1'b0;
    mem_rw_d    = 1'b0;
    mem_dout_d  = 32'd0;

    range_err = (bus.reqAddr >> ADDR_BITS) != 32'd0;
    case (bus.reqFunct3)
      F3_B, F3_H, F3_W: f3_err = 1'b0;
      F3_BU, F3_HU:     f3_err = bus.reqWrite;
      default:          f3_err = 1'b1;
    endcase
    align_err = ((bus.reqFunct3[1:0] == 2'b01) && bus.reqAddr[0]) ||
                ((bus.reqFunct3[1:0] == 2'b10) && (bus.reqAddr[1:0] != 2'b00));

    case (state)
      IDLE: begin
        if (bus.reqValid) begin
          accept = 1'b1;
          if (range_err || f3_err || align_err)
            next_state = RESP;
          else if (bus.reqWrite && (bus.reqFunct3 == F3_W))
            next_state = WRITE;
          else
            next_state = READ;
        end
      end
      READ:    next_state = CAPT;
      CAPT:    next_state = wr_q ? WRITE : RESP;
      WRITE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    ready_d      = (next_state == IDLE);
    resp_valid_d = (next_state == RESP);
    resp_err_d   = (state == IDLE) && (next_state == RESP);
    mem_en_d     = (next_state == READ) || (next_state == WRITE);
    mem_rw_d     = (next_state == WRITE);
    if (next_state == WRITE)
      mem_dout_d = (state == IDLE) ? bus.reqData
                                   : merge(bus.memDataIn, f3_q, lane_q, sdata_q);
    if ((state == CAPT) && (next_state == RESP))
      resp_data_d = extract(bus.memDataIn, f3_q, lane_q);
  end

  // State, request latch and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_q         <= 1'b0;
      f3_q         <= 3'd0;
      lane_q       <= 2'd0;
      sdata_q      <= 16'd0;
      mem_addr_q   <= 32'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 32'd0;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_dout_q   <= 32'd0;
    end else begin
      state        <= next_state;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      mem_en_q     <= mem_en_d;
      mem_rw_q     <= mem_rw_d;
      mem_dout_q   <= mem_dout_d;
      if (accept) begin
        wr_q       <= bus.reqWrite;
        f3_q       <= bus.reqFunct3;
        lane_q     <= bus.reqAddr[1:0];
        sdata_q    <= bus.reqData[15:0];
        mem_addr_q <= {bus.reqAddr[31:2], 2'b00};
      end
    end
  end

  assign bus.reqReady   = ready_q;
  assign bus.respValid  = resp_valid_q;
  assign bus.respErr    = resp_err_q;
  assign bus.respData   = resp_data_q;
  assign bus.memEn      = mem_en_q;
  assign bus.memRw      = mem_rw_q;
  assign bus.memAddr    = mem_addr_q;
  assign bus.memDataOut = mem_dout_q;

`ifdef MEM_ACCESS_COUNTERS_EN
  // Completion counters, bumped as the RESP cycle is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loadCount  <= 16'd0;
      storeCount <= 16'd0;
      errCount   <= 16'd0;
    end else if (next_state == RESP) begin
      if (state == IDLE)  errCount   <= errCount + 16'd1;
      if (state == WRITE) storeCount <= storeCount + 16'd1;
      if (state == CAPT)  loadCount  <= loadCount + 16'd1;
    end
  end
`endif

endmodule
